// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
interface pipe_ctrl_if #(
    parameter int unsigned MC_LEN_W = 6,
    parameter int unsigned CNT_W    = 32
) ();
    localparam int unsigned STALL_W = 6;

    logic                stallreq_id;
    logic                ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic                stallreq_mem;
    logic                flush;
    logic                cnt_clr;
    logic [STALL_W-1:0]  stall;
    logic                ex_mc_busy;
    logic                ex_mc_last;
    logic                flush_o;
    logic [CNT_W-1:0]    stall_cnt;

    // Pipeline side: raises requests, consumes the stall vector.
    modport master (
        output stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem, flush, cnt_clr,
        input  stall, ex_mc_busy, ex_mc_last, flush_o, stall_cnt
    );

    // Controller side.
    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem, flush, cnt_clr,
        output stall, ex_mc_busy, ex_mc_last, flush_o, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: arbitrates ID/EX/MEM stall requests and flush,
// sequences fixed-length EX multi-cycle ops, and counts stalled cycles.
module pipe_ctrl #(
    parameter int unsigned MC_LEN_W = 6,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [MC_LEN_W-1:0] r_q, r_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STALL_W-1:0]  stall_c;
    logic                last_c;
    logic                flush_c;

    // State, remaining-cycle count and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request arbitration and multi-cycle sequencing, highest priority first.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        stall_c = STALL_NONE;
        last_c  = 1'b0;
        flush_c = 1'b0;
        if (rst) begin
            state_d = IDLE;
            r_d     = '0;
        end else if (bus.flush) begin
            // Flush aborts any op in flight and discards a same-cycle start.
            flush_c = 1'b1;
            state_d = IDLE;
            r_d     = '0;
        end else if (bus.stallreq_mem) begin
            // EX is frozen: remaining count holds and an IDLE start waits.
            stall_c = STALL_MEM;
        end else if (state_q == BUSY) begin
            stall_c = STALL_EX;
            if (r_q == MC_LEN_W'(1)) begin
                last_c  = 1'b1;
                state_d = IDLE;
                r_d     = '0;
            end else begin
                r_d = r_q - MC_LEN_W'(1);
            end
        end else if (bus.ex_mc_start && (bus.ex_mc_len != '0)) begin
            // Start cycle counts as the first of the N occupancy cycles.
            stall_c = STALL_EX;
            if (bus.ex_mc_len == MC_LEN_W'(1)) begin
                last_c = 1'b1;
            end else begin
                state_d = BUSY;
                r_d     = bus.ex_mc_len - MC_LEN_W'(1);
            end
        end else if (bus.stallreq_id) begin
            stall_c = STALL_ID;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (stall_c[0] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall      = stall_c;
    assign bus.ex_mc_last = last_c;
    assign bus.flush_o    = flush_c;
    assign bus.ex_mc_busy = (state_q == BUSY);
    assign bus.stall_cnt  = cnt_q;

endmodule
